// File: rtl/eight_point_ifft_if.sv
// Stream bundle for the eight-point IFFT.
// Input side:  in_valid / in_ready handshake carrying one complex bin
//              (in_real, in_imag) per beat.
// Output side: out_valid / out_ready handshake carrying one complex time
//              sample (out_real, out_imag) per beat, out_last marking n = 7.
// busy:        block is computing or draining a frame.
// Modports: master = the side that feeds bins and consumes samples,
//           slave  = the IFFT block itself.
interface eight_point_ifft_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_real;
  logic [W-1:0] in_imag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_real;
  logic [W-1:0] out_imag;
  logic         out_last;
  logic         busy;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_last, busy
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_last, busy
  );
endinterface

// File: rtl/eight_point_ifft.sv
// Sequential 8-point radix-2 DIT inverse FFT with 1/8 normalisation
// (one arithmetic halving per stage). One shared butterfly is iterated
// over 3 stages x 4 butterflies on an 8-entry complex register file.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, aborts any frame in flight
//   bus  - eight_point_ifft_if.slave: bins in, time samples out, busy
// Frame flow: LOAD (8 bins, stored bit-reversed) -> COMPUTE (12 cycles)
//   -> UNLOAD (one cycle to fill the output register, then 8 samples).
// Optional build macro IFFT_SIGN_MAG_EN: bins and samples are
//   sign-magnitude on the bus; internally everything is two's complement.
module eight_point_ifft #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  eight_point_ifft_if.slave  bus
);
  localparam int WE = W + 2;
  localparam logic signed [WE-1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [WE-1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  state_t                state;
  logic [2:0]            cnt;      // load index, then unload index
  logic [1:0]            stage;
  logic [1:0]            bfly;
  logic signed [W-1:0]   mem_re [8];
  logic signed [W-1:0]   mem_im [8];

  // cos(pi/4) approximated by shifts only (~0.70703)
  function automatic logic signed [WE-1:0] c_mul(input logic signed [WE-1:0] v);
    return (v >>> 1) + (v >>> 3) + (v >>> 4) + (v >>> 6) + (v >>> 8);
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [WE-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return v[W-1:0];
  endfunction

  // ---------------- bus format conversion ----------------
  logic               accept;
  logic [2:0]         unl_idx;
  logic signed [W-1:0] load_re, load_im;
  logic [W-1:0]        unl_re, unl_im;

  assign accept  = bus.in_valid && bus.in_ready;
  // Output register is filled with x[0] on the priming cycle, then with
  // the next sample on every handshake.
  assign unl_idx = bus.out_valid ? cnt + 3'd1 : 3'd0;

`ifdef IFFT_SIGN_MAG_EN
  function automatic logic signed [W-1:0] from_sm(input logic [W-1:0] v);
    logic signed [W-1:0] mag;
    mag = {1'b0, v[W-2:0]};
    return v[W-1] ? -mag : mag;   // -0 collapses to 0
  endfunction

  function automatic logic [W-1:0] to_sm(input logic signed [W-1:0] v);
    logic [W-1:0] neg;
    neg = -v;
    if (!v[W-1])                         return v;
    else if (v == SAT_MIN[W-1:0])        return '1;  // -2^(W-1) has no magnitude code
    else                                 return {1'b1, neg[W-2:0]};
  endfunction

  assign load_re = from_sm(bus.in_real);
  assign load_im = from_sm(bus.in_imag);
  assign unl_re  = to_sm(mem_re[unl_idx]);
  assign unl_im  = to_sm(mem_im[unl_idx]);
`else
  assign load_re = bus.in_real;
  assign load_im = bus.in_imag;
  assign unl_re  = mem_re[unl_idx];
  assign unl_im  = mem_im[unl_idx];
`endif

  // ---------------- shared butterfly ----------------
  logic [2:0]           p, q, lo, tk_full;
  logic [1:0]           tk;
  logic signed [WE-1:0] xr, xi, pr, pi, tr, ti, sum_re, sum_im, dif_re, dif_im;
  logic signed [W-1:0]  new_p_re, new_p_im, new_q_re, new_q_im;

  always_comb begin
    // NOTE: every variable gets a value on every path so no latch is inferred.
    lo      = {1'b0, bfly} & ((3'd1 << stage) - 3'd1);           // b mod h
    p       = (({1'b0, bfly} >> stage) << (stage + 2'd1)) | lo;  // (b/h)*2h + b mod h
    q       = p + (3'd1 << stage);
    tk_full = lo << (2'd2 - stage);                              // (b mod h)*(4/h)
    tk      = tk_full[1:0];
    xr      = {{2{mem_re[q][W-1]}}, mem_re[q]};
    xi      = {{2{mem_im[q][W-1]}}, mem_im[q]};
    pr      = {{2{mem_re[p][W-1]}}, mem_re[p]};
    pi      = {{2{mem_im[p][W-1]}}, mem_im[p]};
    // t = x[q] * e^{+j*2*pi*tk/8}
    case (tk)
      2'd0:    begin tr = xr;              ti = xi;              end
      2'd1:    begin tr = c_mul(xr - xi);  ti = c_mul(xr + xi);  end
      2'd2:    begin tr = -xi;             ti = xr;              end
      default: begin tr = -c_mul(xr + xi); ti = c_mul(xr - xi);  end
    endcase
    sum_re   = (pr + tr) >>> 1;
    sum_im   = (pi + ti) >>> 1;
    dif_re   = (pr - tr) >>> 1;
    dif_im   = (pi - ti) >>> 1;
    new_p_re = sat(sum_re);
    new_p_im = sat(sum_im);
    new_q_re = sat(dif_re);
    new_q_im = sat(dif_im);
  end

  // NOTE: the register file has no reset; a new frame always overwrites all
  // eight entries before they are read, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (state == LOAD && accept) begin
      mem_re[{cnt[0], cnt[1], cnt[2]}] <= load_re;   // bit-reversed address
      mem_im[{cnt[0], cnt[1], cnt[2]}] <= load_im;
    end else if (state == COMPUTE) begin
      mem_re[p] <= new_p_re;
      mem_im[p] <= new_p_im;
      mem_re[q] <= new_q_re;
      mem_im[q] <= new_q_im;
    end
  end

  // ---------------- control FSM with registered outputs ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD;
      cnt           <= '0;
      stage         <= '0;
      bfly          <= '0;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_real  <= '0;
      bus.out_imag  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            cnt <= cnt + 3'd1;   // wraps to 0 after the 8th bin
            if (cnt == 3'd7) begin
              state        <= COMPUTE;
              bus.in_ready <= 1'b0;
              bus.busy     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (bfly == 2'd3) begin
            bfly <= '0;
            if (stage == 2'd2) begin
              stage <= '0;
              state <= UNLOAD;
            end else begin
              stage <= stage + 2'd1;
            end
          end else begin
            bfly <= bfly + 2'd1;
          end
        end
        UNLOAD: begin
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_real  <= unl_re;
            bus.out_imag  <= unl_im;
            bus.out_last  <= 1'b0;
          end else if (bus.out_ready) begin
            if (cnt == 3'd7) begin
              state         <= LOAD;
              cnt           <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.in_ready  <= 1'b1;
              bus.busy      <= 1'b0;
            end else begin
              cnt          <= cnt + 3'd1;
              bus.out_real <= unl_re;
              bus.out_imag <= unl_im;
              bus.out_last <= (cnt == 3'd6);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
